cpu_run_ctrl: RTL

- Sequencer for the five-stage cpu through its external memory ports and its enable input.
- Loads a program into instruction memory and initial data into data memory from a valid/ready word stream.
- Then asserts cpu enable for a programmed number of cycles, then reads a window of data memory back out on a valid/ready stream.
- Sits between the testbench/host link and cpu; the only driver of cpu enable, addr_ext*, wen_ext*, ren_ext*, wdata_ext*.

---
 rtl/cpu_run_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Load/run/dump sequencer for the five-stage cpu: streams a program and data image into
// its memories, enables it for a fixed cycle count, then streams a data window back out.
// Optional load checksum is built when RUN_CTRL_CHECKSUM_EN is defined.

module cpu_run_ctrl #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter logic [31:0] IMEM_BASE = 32'd0,
    parameter logic [31:0] DMEM_BASE = 32'd0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_imem_words,
    input  logic [CNT_W-1:0] cfg_dmem_words,
    input  logic [CNT_W-1:0] cfg_run_cycles,
    input  logic [CNT_W-1:0] cfg_dump_words,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic             cpu_enable,
    output logic [31:0]      imem_addr,
    output logic             imem_wen,
    output logic [31:0]      imem_wdata,
    output logic [31:0]      dmem_addr,
    output logic             dmem_wen,
    output logic             dmem_ren,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_LD_I     = 4'd1;
    localparam logic [3:0] ST_LD_D     = 4'd2;
    localparam logic [3:0] ST_GAP      = 4'd3;
    localparam logic [3:0] ST_RUN      = 4'd4;
    localparam logic [3:0] ST_DUMP_RD  = 4'd5;
    localparam logic [3:0] ST_DUMP_WT  = 4'd6;
    localparam logic [3:0] ST_DUMP_OUT = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic [3:0]       after_load;
    logic [CNT_W-1:0] imem_words;
    logic [CNT_W-1:0] dmem_words;
    logic [CNT_W-1:0] run_cycles;
    logic [CNT_W-1:0] dump_words;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cur_count;
    logic [CNT_W-1:0] rd_idx;
    logic             launch;
    logic             accept;
    logic             handshake;
    logic             last;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [CNT_W-1:0] i);
        return base + 32'(i) * ADDR_STEP;
    endfunction

    function automatic logic [3:0] first_phase(input logic [CNT_W-1:0] i_words,
                                               input logic [CNT_W-1:0] d_words,
                                               input logic [CNT_W-1:0] r_cycles,
                                               input logic [CNT_W-1:0] u_words);
        if (i_words != '0)       return ST_LD_I;
        else if (d_words != '0)  return ST_LD_D;
        else if (r_cycles != '0) return ST_RUN;
        else if (u_words != '0)  return ST_DUMP_RD;
        else                     return ST_DONE;
    endfunction

    assign s_ready   = (state == ST_LD_I) || (state == ST_LD_D);
    assign accept    = s_ready && s_valid;
    assign handshake = m_valid && m_ready;
    assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));

    // One idx counter serves every phase; it is cleared at each phase end.
    always_comb begin
        cur_count = '0;
        case (state)
            ST_LD_I:     cur_count = imem_words;
            ST_LD_D:     cur_count = dmem_words;
            ST_RUN:      cur_count = run_cycles;
            ST_DUMP_OUT: cur_count = dump_words;
            default:     cur_count = '0;
        endcase
    end

    assign last   = (idx == cur_count - 1'b1);
    assign rd_idx = (state == ST_DUMP_OUT) ? idx + 1'b1 : '0;

    // The last load write lands in the cycle after the load ends, so GAP is also used
    // before a dump with no run, keeping the final dmem write clear of the first read.
    assign after_load = ((run_cycles != '0) || (dump_words != '0)) ? ST_GAP : ST_DONE;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start)
                    next_state = first_phase(cfg_imem_words, cfg_dmem_words,
                                             cfg_run_cycles, cfg_dump_words);
            end
            ST_LD_I: begin
                if (accept && last)
                    next_state = (dmem_words != '0) ? ST_LD_D : after_load;
            end
            ST_LD_D: begin
                if (accept && last)
                    next_state = after_load;
            end
            ST_GAP:      next_state = (run_cycles != '0) ? ST_RUN : ST_DUMP_RD;
            ST_RUN: begin
                if (last)
                    next_state = (dump_words != '0) ? ST_DUMP_RD : ST_DONE;
            end
            ST_DUMP_RD:  next_state = ST_DUMP_WT;
            ST_DUMP_WT:  next_state = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (handshake)
                    next_state = last ? ST_DONE : ST_DUMP_RD;
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    // Control outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_enable <= 1'b0;
            dmem_ren   <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != ST_IDLE) && (next_state != ST_DONE);
            done       <= (next_state == ST_DONE);
            cpu_enable <= (next_state == ST_RUN);
            dmem_ren   <= (next_state == ST_DUMP_RD);
            m_valid    <= (next_state == ST_DUMP_OUT);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            imem_words <= '0;
            dmem_words <= '0;
            run_cycles <= '0;
            dump_words <= '0;
            idx        <= '0;
        end else if (launch) begin
            imem_words <= cfg_imem_words;
            dmem_words <= cfg_dmem_words;
            run_cycles <= cfg_run_cycles;
            dump_words <= cfg_dump_words;
            idx        <= '0;
        end else if (accept || (state == ST_RUN) || ((state == ST_DUMP_OUT) && handshake)) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_wen   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            imem_wen <= 1'b0;
            dmem_wen <= 1'b0;
            if (accept && (state == ST_LD_I)) begin
                imem_wen   <= 1'b1;
                imem_addr  <= word_addr(IMEM_BASE, idx);
                imem_wdata <= s_data;
            end
            if (accept && (state == ST_LD_D)) begin
                dmem_wen   <= 1'b1;
                dmem_addr  <= word_addr(DMEM_BASE, idx);
                dmem_wdata <= s_data;
            end else if (next_state == ST_DUMP_RD) begin
                dmem_addr  <= word_addr(DMEM_BASE, rd_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            m_data <= '0;
        else if (state == ST_DUMP_WT)
            m_data <= dmem_rdata;
    end

`ifdef RUN_CTRL_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            csum <= '0;
        else if (launch)
            csum <= '0;
        else if (accept)
            csum <= csum ^ s_data;
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif

    a_no_rw_clash: assert property (@(posedge clk) disable iff (!arst_n)
        !(dmem_wen && dmem_ren));

    a_enable_in_run: assert property (@(posedge clk) disable iff (!arst_n)
        cpu_enable |-> (state == ST_RUN));

    a_mdata_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
